// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS datapath.
// Register-file geometry and named architectural registers.
package mips_pkg;

  localparam int REG_W      = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;
  localparam reg_addr_t REG_SP   = 5'd29;
  localparam reg_addr_t REG_RA   = 5'd31;

endpackage

// File: rtl/mips_register_file_if.sv
// Register-file access bundle: two read ports, one write port, debug read.
// master = datapath side, slave = register file.
interface mips_register_file_if
  import mips_pkg::*;
#(
  parameter int WIDTH      = REG_W,
  parameter int DEPTH_LOG2 = REG_ADDR_W
);

  logic [DEPTH_LOG2-1:0] A1;
  logic [DEPTH_LOG2-1:0] A2;
  logic [DEPTH_LOG2-1:0] A3;
  logic [WIDTH-1:0]      WD3;
  logic                  WE3;
  logic [WIDTH-1:0]      RD1;
  logic [WIDTH-1:0]      RD2;
  logic [DEPTH_LOG2-1:0] DbgA;
  logic [WIDTH-1:0]      DbgRD;

  modport master (
    output A1, A2, A3, WD3, WE3, DbgA,
    input  RD1, RD2, DbgRD
  );

  modport slave (
    input  A1, A2, A3, WD3, WE3, DbgA,
    output RD1, RD2, DbgRD
  );

endinterface

// File: rtl/mips_register_file.sv
// 32 x 32 MIPS register file, $0 hardwired to zero.
// Combinational reads, one synchronous write, optional write-first bypass.
module mips_register_file
  import mips_pkg::*;
#(
  parameter int WIDTH      = REG_W,
  parameter int DEPTH_LOG2 = REG_ADDR_W,
  parameter int BYPASS     = 0
) (
  input logic                CLK,
  input logic                RST,
  mips_register_file_if.slave rf
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [WIDTH-1:0] regs [DEPTH];
  logic             wr_en;

  // X on WE3/A3 evaluates false here, so $0 can never be corrupted.
  always_comb begin
    wr_en = 1'b0;
    if (rf.WE3 && !RST && (rf.A3 != '0))
      wr_en = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else if (wr_en) begin
      regs[rf.A3] <= rf.WD3;
    end
  end

  always_comb begin
    rf.RD1 = '0;
    if (rf.A1 != '0) begin
      if ((BYPASS != 0) && wr_en && (rf.A1 == rf.A3))
        rf.RD1 = rf.WD3;
      else
        rf.RD1 = regs[rf.A1];
    end
  end

  always_comb begin
    rf.RD2 = '0;
    if (rf.A2 != '0) begin
      if ((BYPASS != 0) && wr_en && (rf.A2 == rf.A3))
        rf.RD2 = rf.WD3;
      else
        rf.RD2 = regs[rf.A2];
    end
  end

  always_comb begin
    rf.DbgRD = '0;
    if (rf.DbgA != '0)
      rf.DbgRD = regs[rf.DbgA];
  end

  always @(posedge CLK) begin
    if (!RST)
      assert (!$isunknown(rf.WE3))
        else $error("WE3 is unknown while out of reset");
  end

endmodule

// File: tb/tb_mips_register_file.sv
// Directed bench for mips_register_file, bypass off and on.
// Both instances see identical stimulus.
module tb_mips_register_file;
  import mips_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mips_register_file_if ifa ();
  mips_register_file_if ifb ();

  assign ifb.A1   = ifa.A1;
  assign ifb.A2   = ifa.A2;
  assign ifb.A3   = ifa.A3;
  assign ifb.WD3  = ifa.WD3;
  assign ifb.WE3  = ifa.WE3;
  assign ifb.DbgA = ifa.DbgA;

  mips_register_file #(.BYPASS(0)) dut0 (
    .CLK (clk),
    .RST (rst),
    .rf  (ifa.slave)
  );

  mips_register_file #(.BYPASS(1)) dut1 (
    .CLK (clk),
    .RST (rst),
    .rf  (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  alu_ctrl;
  logic [31:0] alu_res;
  logic        alu_zero;

  always_comb begin
    alu_res = '0;
    case (alu_ctrl)
      3'b000:  alu_res = ifa.RD1 & ifa.RD2;
      3'b001:  alu_res = ifa.RD1 | ifa.RD2;
      3'b010:  alu_res = ifa.RD1 + ifa.RD2;
      3'b100:  alu_res = ifa.RD1 - ifa.RD2;
      default: alu_res = '0;
    endcase
    alu_zero = (alu_res == 32'd0);
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input reg_addr_t a, input logic [31:0] d);
    ifa.WE3 = 1'b1;
    ifa.A3  = a;
    ifa.WD3 = d;
    step();
    ifa.WE3 = 1'b0;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    alu_ctrl = 3'b000;
    rst      = 1'b1;
    ifa.A1   = '0;
    ifa.A2   = '0;
    ifa.A3   = '0;
    ifa.WD3  = '0;
    ifa.WE3  = 1'b0;
    ifa.DbgA = '0;
    step();
    step();
    rst = 1'b0;

    ifa.A1 = REG_RA;
    ifa.A2 = REG_SP;
    ifa.DbgA = 5'd1;
    #1;
    check("rst_rd1", ifa.RD1, 32'h0);
    check("rst_rd2", ifa.RD2, 32'h0);
    check("rst_dbg", ifa.DbgRD, 32'h0);

    for (int i = 1; i < 32; i++)
      wr(reg_addr_t'(i), 32'hDEAD_BEEF);
    ifa.DbgA = 5'd17;
    #1;
    check("fill_dbg17", ifa.DbgRD, 32'hDEAD_BEEF);
    ifa.DbgA = REG_RA;
    #1;
    check("fill_dbg31", ifa.DbgRD, 32'hDEAD_BEEF);
    ifa.DbgA = REG_ZERO;
    #1;
    check("fill_dbg0", ifa.DbgRD, 32'h0);

    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ifa.DbgA = reg_addr_t'(i);
      #1;
      check($sformatf("clr_dbg0_%0d", i), ifa.DbgRD, 32'h0);
      check($sformatf("clr_dbg1_%0d", i), ifb.DbgRD, 32'h0);
    end

    wr(5'd8, 32'h0000_1234);
    ifa.A1 = 5'd8;
    ifa.A2 = 5'd9;
    #1;
    check("basic_rd1", ifa.RD1, 32'h0000_1234);
    check("basic_rd2", ifa.RD2, 32'h0);

    ifa.WE3 = 1'b1;
    ifa.A3  = REG_ZERO;
    ifa.WD3 = 32'hFFFF_FFFF;
    ifa.A1  = REG_ZERO;
    #1;
    check("z_same_b0", ifa.RD1, 32'h0);
    check("z_same_b1", ifb.RD1, 32'h0);
    step();
    ifa.WE3 = 1'b0;
    ifa.DbgA = REG_ZERO;
    #1;
    check("z_next_rd1", ifa.RD1, 32'h0);
    check("z_next_dbg", ifa.DbgRD, 32'h0);

    wr(5'd5, 32'h11);
    ifa.WE3 = 1'b1;
    ifa.A3  = 5'd5;
    ifa.WD3 = 32'h22;
    ifa.A1  = 5'd5;
    ifa.A2  = 5'd5;
    ifa.DbgA = 5'd5;
    #1;
    check("col_b0_rd1", ifa.RD1, 32'h11);
    check("col_b0_rd2", ifa.RD2, 32'h11);
    check("col_b1_rd1", ifb.RD1, 32'h22);
    check("col_b1_rd2", ifb.RD2, 32'h22);
    check("col_b1_dbg", ifb.DbgRD, 32'h11);
    step();
    ifa.WE3 = 1'b0;
    ifa.WD3 = 32'h99;
    #1;
    check("col_next_rd1", ifa.RD1, 32'h22);
    check("col_next_rd2", ifa.RD2, 32'h22);
    check("we0_b1_rd1", ifb.RD1, 32'h22);
    step();
    check("we0_hold", ifa.RD1, 32'h22);

    wr(5'd3, 32'h55);
    rst     = 1'b1;
    ifa.WE3 = 1'b1;
    ifa.A3  = 5'd3;
    ifa.WD3 = 32'h77;
    ifa.A1  = 5'd3;
    #1;
    check("rstw_b1_nobyp", ifb.RD1, 32'h55);
    step();
    rst     = 1'b0;
    ifa.WE3 = 1'b0;
    ifa.A2  = 5'd8;
    #1;
    check("rstw_b0_r3", ifa.RD1, 32'h0);
    check("rstw_b1_r3", ifb.RD1, 32'h0);
    check("rstw_r8", ifa.RD2, 32'h0);

    wr(REG_RA, 32'hCAFE_F00D);
    ifa.A2 = REG_RA;
    #1;
    check("ra_rd2", ifa.RD2, 32'hCAFE_F00D);

    wr(5'd1, 32'd7);
    wr(5'd2, 32'd5);
    ifa.A1   = 5'd1;
    ifa.A2   = 5'd2;
    alu_ctrl = 3'b100;
    #1;
    check("alu_sub", alu_res, 32'd2);
    check("alu_zero", {31'd0, alu_zero}, 32'd0);
    wr(5'd3, alu_res);
    ifa.A1 = 5'd3;
    #1;
    check("wb_r3", ifa.RD1, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_register_file.md
Name: mips_register_file

Overview:
- 32 x 32-bit general-purpose register file for the single-cycle MIPS datapath. Sits directly upstream of the ALU.
- RD1 drives ALU SrcA. RD2 drives the SrcB mux and the data-memory write data.
- Write-back of ALUResult or load data returns through port 3.
- Register $0 is hardwired to zero. One extra read port is provided for testbench/debug observation.

Parameters:
- WIDTH, 32, data width of each register.
- DEPTH_LOG2, 5, address width; the file holds 2**DEPTH_LOG2 registers.
- BYPASS, 0, 1 = a read of the register being written in the same cycle returns WD3 (write-first); 0 = returns the old contents.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- A1  in  DEPTH_LOG2  read address, port 1 (instr rs).
- A2  in  DEPTH_LOG2  read address, port 2 (instr rt).
- A3  in  DEPTH_LOG2  write address (rt or rd, selected upstream by RegDst).
- WD3  in  WIDTH  write data (ALUResult or memory read data).
- WE3  in  1  write enable (RegWrite).
- RD1  out  WIDTH  read data, port 1, to ALU SrcA.
- RD2  out  WIDTH  read data, port 2, to SrcB mux / memory.
- DbgA  in  DEPTH_LOG2  debug read address.
- DbgRD  out  WIDTH  debug read data.

Behaviour:
- Storage: array of 2**DEPTH_LOG2 registers, each WIDTH bits. Register 0 is never written and always reads 0.
- Reset:
  - RST=1 at a rising CLK edge clears every register to 0. RST takes priority over WE3 in the same cycle.
  - Asserting RST mid-operation discards any write presented that cycle.
  - From the edge after RST is sampled high, RD1, RD2 and DbgRD read 0 for every address until a new write lands.
- Reads:
  - Combinational, zero latency. RDn = reg[An] in the same cycle. A read of address 0 returns 0 regardless of any other input.
  - DbgRD behaves the same as RD1/RD2 but is never bypassed.
- Writes:
  - When WE3=1, RST=0 and A3!=0, reg[A3] <= WD3 on the rising edge.
  - WE3=1 with A3=0 is a legal no-op.
  - WE3=0 leaves all state unchanged regardless of A3/WD3.
- Bypass:
  - BYPASS=1: if WE3=1, A3!=0, RST=0 and An==A3, RDn = WD3 combinationally in that cycle.
  - BYPASS=0 (default, single-cycle datapath): RDn shows the old value; the new value is visible from the next cycle.
  - A1==A2==A3 is legal. Both read ports follow the same rule.
- Timing: write-to-read latency is 1 edge (BYPASS=0) or 0 (BYPASS=1). There is no stall or handshake; a write is accepted every cycle.
- Widths: no arithmetic. All addresses are unsigned. There are no out-of-range addresses because the depth is exactly 2**DEPTH_LOG2.
- X-handling: WE3=X or A3=X during simulation must not corrupt $0. Assertions flag X on WE3 when RST=0.

Decomposition:
- Shared package mips_pkg:
  - REG_W=32, REG_ADDR_W=5.
  - Named register constants: REG_ZERO=0, REG_SP=29, REG_RA=31.
  - Typedef reg_addr_t.
- No sub-module: a single always block for writes plus combinational read and bypass muxes. A read-port mux helper is not worth splitting out.

Test Plan:
- Reset: write 32'hDEADBEEF to regs 1..31, pulse RST one cycle, then sweep DbgA 0..31 -> DbgRD=0 for all addresses.
- Basic write/read: WE3=1, A3=8, WD3=32'h0000_1234; next cycle A1=8 -> RD1=32'h0000_1234. A2=9 (never written) -> RD2=0.
- $0 protection: WE3=1, A3=0, WD3=32'hFFFF_FFFF; next cycle A1=0 -> RD1=0.
- Same-cycle read/write collision:
  - Setup: reg5=32'h11; then in one cycle WE3=1, A3=5, WD3=32'h22, A1=A2=5.
  - BYPASS=0 -> RD1=RD2=32'h11, then 32'h22 the next cycle.
  - BYPASS=1 -> RD1=RD2=32'h22 in the same cycle.
- Reset beats write: RST=1 and WE3=1, A3=3, WD3=32'h77 in the same cycle -> reg3=0 next cycle.
- Datapath smoke test: program reg1=7, reg2=5 and connect RD1/RD2 to the ALU with ALUControl=100 (subtract) -> ALUResult=2, Zero=0. Write ALUResult back to reg3 -> next cycle reg3=2.
